// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle_rx receiver: default parameters,
// counter width and the receive FSM state encoding.
package toggle_pkg;

    localparam int unsigned DW_DEFAULT          = 8;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned CNT_W               = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/toggle_if.sv
// Two-phase request/acknowledge link plus the downstream valid/ready
// output of the receiver. The master modport is the sender/consumer side,
// and the slave modport is the toggle_rx side.
interface toggle_if
    import toggle_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
);

    logic          req_t;
    logic [DW-1:0] data_in;
    logic          ack_t;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          overrun;

    modport master (
        output req_t, data_in, dout_ready,
        input  ack_t, dout, dout_valid, overrun
    );

    modport slave (
        input  req_t, data_in, dout_ready,
        output ack_t, dout, dout_valid, overrun
    );

endinterface

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer for the asynchronous two-phase request level.
// The legal depth is 2..4.
module toggle_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Two-phase (toggle) handshake receiver with a downstream valid/ready output
// and a sticky overrun flag.
// Optional feature: define TOGGLE_RX_CNT_EN to add the 16-bit xfer_cnt output.
module toggle_rx
    import toggle_pkg::*;
#(
    parameter int unsigned DW          = DW_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    toggle_if.slave          bus
`ifdef TOGGLE_RX_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    logic          w_req_sync;
    logic          w_handshake;
    logic          r_hist;
    logic          r_edge;
    state_t        r_state;
    logic          r_ack;
    logic          r_valid;
    logic          r_ovr;
    logic [DW-1:0] r_dout;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.req_t),
        .q   (w_req_sync)
    );

    // History flop and registered edge pulse. The extra register places the
    // capture on the (SYNC_STAGES+2)th edge after the req_t change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_hist <= w_req_sync;
            r_edge <= w_req_sync ^ r_hist;
        end
    end

    assign w_handshake = (r_state == ST_HOLD) && r_valid && bus.dout_ready;

    // Receive FSM: capture on an edge in IDLE, then release on the downstream
    // handshake. An edge that arrives while in HOLD, including in the exit
    // cycle, is discarded and flagged as an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_edge) begin
                        r_dout  <= bus.data_in;
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_edge) r_ovr <= 1'b1;
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_ack   <= ~r_ack;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef TOGGLE_RX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Count completed handshakes. The counter wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_cnt <= '0;
        else if (w_handshake) r_cnt <= r_cnt + 1'b1;
    end

    assign xfer_cnt = r_cnt;
`endif

    assign bus.ack_t      = r_ack;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_valid;
    assign bus.overrun    = r_ovr;

endmodule

// File: tb/tb_toggle_rx.sv
// Directed self-checking bench for toggle_rx (SYNC_STAGES = 2, DW = 8).
// Inputs change on the falling edge. Outputs are sampled 1 ns after the rising edge.
module tb_toggle_rx;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    toggle_if #(.DW(8)) bus ();

`ifdef TOGGLE_RX_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    toggle_rx #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef TOGGLE_RX_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: stops the run if it somehow stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_t = 1'b0;
        bus.data_in = 8'h00;
        bus.dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.ack_t !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack_t); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.dout_valid); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step();
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_spurious_valid: got %b want 0", bus.dout_valid); end
        checks++; if (bus.ack_t !== 1'b0) begin errors++; $display("FAIL reset_spurious_ack: got %b want 0", bus.ack_t); end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.data_in = 8'hA5;
        bus.dout_ready = 1'b1;
        bus.req_t = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid edge %0d: got %b want 0", i, bus.dout_valid); end
        end
        step();
        checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid_edge4: got %b want 1", bus.dout_valid); end
        checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL single_dout: got %h want a5", bus.dout); end
        checks++; if (bus.ack_t !== 1'b0) begin errors++; $display("FAIL single_ack_before: got %b want 0", bus.ack_t); end
        step();
        checks++; if (bus.ack_t !== 1'b1) begin errors++; $display("FAIL single_ack_after: got %b want 1", bus.ack_t); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %b want 0", bus.dout_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.dout_ready = 1'b0;
        bus.data_in = 8'h3C;
        bus.req_t = 1'b0;
        repeat (4) step();
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h3C) begin errors++; $display("FAIL bp_capture: got valid=%b dout=%h want 1/3c", bus.dout_valid, bus.dout); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h3C || bus.ack_t !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b dout=%h ack=%b want 1/3c/1", i, bus.dout_valid, bus.dout, bus.ack_t);
            end
        end
        @(negedge clk);
        bus.dout_ready = 1'b1;
        step();
        checks++; if (bus.ack_t !== 1'b0) begin errors++; $display("FAIL bp_ack_toggle: got %b want 0", bus.ack_t); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_clear: got %b want 0", bus.dout_valid); end
        @(negedge clk);
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_overrun();
        @(negedge clk);
        bus.data_in = 8'h5A;
        bus.req_t = 1'b1;
        @(negedge clk);
        bus.req_t = 1'b0;
        repeat (6) step();
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h5A) begin errors++; $display("FAIL ovr_capture: got valid=%b dout=%h want 1/5a", bus.dout_valid, bus.dout); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
        checks++; if (bus.ack_t !== 1'b0) begin errors++; $display("FAIL ovr_ack_held: got %b want 0", bus.ack_t); end
        @(negedge clk);
        bus.dout_ready = 1'b1;
        step();
        checks++; if (bus.ack_t !== 1'b1) begin errors++; $display("FAIL ovr_ack_toggle: got %b want 1", bus.ack_t); end
        repeat (10) step();
        checks++; if (bus.ack_t !== 1'b1 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ovr_single_word: got ack=%b valid=%b want 1/0", bus.ack_t, bus.dout_valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
        @(negedge clk);
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        bus.data_in = 8'h77;
        bus.req_t = 1'b1;
        repeat (4) step();
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h77 || bus.ack_t !== 1'b1) begin errors++; $display("FAIL rsthold_pre: got valid=%b dout=%h ack=%b want 1/77/1", bus.dout_valid, bus.dout, bus.ack_t); end
        #2;
        rst = 1'b1;
        bus.req_t = 1'b0;
        #1;
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rsthold_valid: got %b want 0", bus.dout_valid); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rsthold_dout: got %h want 00", bus.dout); end
        checks++; if (bus.ack_t !== 1'b0) begin errors++; $display("FAIL rsthold_ack: got %b want 0", bus.ack_t); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rsthold_overrun: got %b want 0", bus.overrun); end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step();
        checks++; if (bus.dout_valid !== 1'b0 || bus.ack_t !== 1'b0) begin errors++; $display("FAIL rsthold_idle: got valid=%b ack=%b want 0/0", bus.dout_valid, bus.ack_t); end
    endtask

    task automatic test_after_reset();
        @(negedge clk);
        bus.data_in = 8'h96;
        bus.dout_ready = 1'b1;
        bus.req_t = 1'b1;
        repeat (4) step();
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h96) begin errors++; $display("FAIL post_capture: got valid=%b dout=%h want 1/96", bus.dout_valid, bus.dout); end
        step();
        checks++; if (bus.ack_t !== 1'b1 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL post_ack: got ack=%b valid=%b want 1/0", bus.ack_t, bus.dout_valid); end
`ifdef TOGGLE_RX_CNT_EN
        checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL post_cnt: got %0d want 1", xfer_cnt); end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_overrun();
        test_reset_hold();
        test_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 SHALL have parameter DW, default 8, data width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, req_t synchronizer depth; legal range 2..4.
REQ-003 SHALL have port clk  input  1  single clock; all flops rise-edge triggered.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_t  input  1  two-phase request from sender T flip-flop; each level change is one transfer; asynchronous to clk.
REQ-006 SHALL have port data_in  input  DW  sender data; stable from the req_t change until the matching ack_t change.
REQ-007 SHALL have port ack_t  output  1  two-phase acknowledge; toggles once per accepted transfer.
REQ-008 SHALL have port dout  output  DW  captured data.
REQ-009 SHALL have port dout_valid  output  1  dout holds an unconsumed word.
REQ-010 SHALL have port dout_ready  input  1  downstream accepts dout.
REQ-011 SHALL have port overrun  output  1  sticky error flag: req_t edge seen while busy.

Function
REQ-012 SHALL pass req_t through SYNC_STAGES flops, plus one history flop; edge = last stage XOR history.
REQ-013 SHALL implement states IDLE and HOLD.
- IDLE: on edge, load dout <= data_in, set dout_valid, go to HOLD.
- HOLD: on dout_valid && dout_ready, clear dout_valid, toggle ack_t, go to IDLE.
REQ-014 SHALL assert dout_valid on the (SYNC_STAGES+2)th rising clk edge after a req_t change that meets setup to the first sync stage.
REQ-015 SHALL toggle ack_t on the same edge that clears dout_valid; ack_t is a registered output.
REQ-016 SHALL hold dout constant while dout_valid=1 and while dout_ready=0 for any number of cycles.
REQ-017 SHALL treat an edge in HOLD as overrun: the edge is discarded, no capture, no ack_t toggle, overrun set to 1.
REQ-018 SHALL treat an edge coinciding with the HOLD-exit handshake cycle as overrun per REQ-017.
REQ-019 SHALL keep overrun set until reset; it SHALL NOT affect normal transfers.
REQ-020 SHALL ignore dout_ready while in IDLE.

Reset
REQ-021 SHALL on rst: sync and history flops 0, state IDLE, ack_t 0, dout 0, dout_valid 0, overrun 0.
REQ-022 SHALL abandon any transfer in progress on reset mid-HOLD; the pending word is lost and ack_t returns to 0.
REQ-023 SHALL, with sender also reset to req_t=0, detect no spurious edge after reset release.

Configuration
REQ-024 SHALL, when TOGGLE_RX_CNT_EN is defined, add output xfer_cnt (16 bit), reset 0, incremented on each completed handshake, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL, when TOGGLE_RX_CNT_EN is undefined, omit xfer_cnt and its logic; all other behaviour identical.

Structure
REQ-026 SHALL place the state enum typedef and default DW / SYNC_STAGES constants in shared package toggle_pkg.
REQ-027 SHALL implement the synchronizer as sub-module toggle_sync (parameter SYNC_STAGES, ports clk, rst, d, q).

Verification
REQ-028 Reset: rst=1 for 3 cycles with req_t=0 -> ack_t=0, dout_valid=0, dout=0, overrun=0; no transfer after release.
REQ-029 Single transfer: data_in=0xA5, req_t 0->1, dout_ready=1 -> dout_valid high at clk edge SYNC_STAGES+2 with dout=0xA5; ack_t 0->1 on the next edge.
REQ-030 Backpressure: data_in=0x3C, dout_ready=0 for 10 cycles -> dout_valid and dout=0x3C held; ack_t unchanged; ack_t toggles on the edge dout_ready goes 1.
REQ-031 Overrun: req_t toggles twice, 1 cycle apart, dout_ready=0 -> one word captured, overrun=1, ack_t toggles exactly once after release.
REQ-032 Reset mid-HOLD: rst during HOLD with dout=0x77 -> dout_valid=0, dout=0, ack_t=0 immediately (asynchronous), state IDLE.
REQ-033 With TOGGLE_RX_CNT_EN: preload counter path to 0xFFFF via 65535 transfers, one more -> xfer_cnt=0x0000.
